// File: rtl/minterm_sweep_pkg.sv
// -----------------------------------------------------------------------------
// minterm_sweep_pkg
// Shared definitions for the minterm sweep controller:
//   - sweep FSM state encoding
//   - truth-table geometry (N_IN inputs, TT_W = 2**N_IN entries)
//   - GOLDEN_MASK: truth table of F = A&(C&D | B) | B&~C, handy for benches
//   - popcount helper used to turn a mismatch vector into an error count
// -----------------------------------------------------------------------------
package minterm_sweep_pkg;

    localparam int N_IN  = 4;
    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = $clog2(TT_W + 1);

    localparam logic [TT_W-1:0] GOLDEN_MASK = 16'hF830;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } sweep_state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [TT_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < TT_W; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sweep_settle_ctr.sv
// -----------------------------------------------------------------------------
// sweep_settle_ctr
// Down-counter that times how long each minterm is held before sampling.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_clr        : force count to zero (highest priority after reset)
//   i_load       : load i_load_val
//   i_load_val   : value loaded on i_load
//   i_en         : decrement while non-zero
//   o_term       : count has reached zero
// -----------------------------------------------------------------------------
module sweep_settle_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_term
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_term = (r_cnt == '0);

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// minterm_sweep_ctrl
// Walks a 4-input combinational block through all 16 minterms, holds each one
// for SETTLE_CYCLES extra cycles, samples F in the last cycle of the slot,
// builds the truth table and compares it with an expected mask.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a sweep (accepted only in IDLE)
//   abort             : cancel a sweep in progress (SETTLE/SAMPLE only)
//   expected[15:0]    : expected truth table, captured on accepted start
//   dut_f             : F output of the block under control
//   dut_a..dut_d      : minterm drive, A = bit 3 (MSB) .. D = bit 0 (LSB)
//   busy              : sweep in progress
//   done              : one-cycle completion pulse
//   aborted           : one-cycle pulse when an abort is taken
//   truth[15:0]       : captured truth table
//   mismatch[15:0]    : truth ^ captured expected, valid from done
//   err_count[4:0]    : popcount(mismatch)
//   pass              : err_count == 0, valid from done
// -----------------------------------------------------------------------------
module minterm_sweep_ctrl
    import minterm_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int N_IN          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [TT_W-1:0]  expected,
    input  logic             dut_f,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [TT_W-1:0]  truth,
    output logic [TT_W-1:0]  mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic             pass
);

    // Counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts SETTLE_CYCLES cycles.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam sweep_state_t AFTER_LOAD = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    localparam logic [N_IN-1:0] M_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] M_LAST = '1;

    sweep_state_t r_state;
    sweep_state_t w_state_nxt;

    logic             w_accept;
    logic             w_sample;
    logic             w_finish;
    logic             w_abort_take;
    logic             w_ctr_load;
    logic             w_ctr_term;

    logic [N_IN-1:0]  r_m;
    logic [TT_W-1:0]  r_exp_q;
    logic [TT_W-1:0]  r_truth;
    logic [TT_W-1:0]  r_mismatch;
    logic [CNT_W-1:0] r_err_count;
    logic             r_pass;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;

    sweep_settle_ctr #(.W(4)) u_settle_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_abort_take | w_finish),
        .i_load     (w_ctr_load),
        .i_load_val (SETTLE_LOAD),
        .i_en       (r_state == SETTLE),
        .o_term     (w_ctr_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_finish     = 1'b0;
        w_abort_take = 1'b0;
        w_ctr_load   = 1'b0;
        case (r_state)
            IDLE: begin
                // abort is meaningless here; a simultaneous start still wins
                if (start) begin
                    w_accept    = 1'b1;
                    w_ctr_load  = 1'b1;
                    w_state_nxt = AFTER_LOAD;
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_abort_take = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (w_ctr_term) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                // abort beats the sample so truth only holds completed minterms
                if (abort) begin
                    w_abort_take = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    w_sample = 1'b1;
                    if (r_m == M_LAST) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_ctr_load  = 1'b1;
                        w_state_nxt = AFTER_LOAD;
                    end
                end
            end
            FINISH: begin
                w_finish    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m         <= '0;
            r_exp_q     <= '0;
            r_truth     <= '0;
            r_mismatch  <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_done    <= w_finish;
            r_aborted <= w_abort_take;
            if (w_accept) begin
                r_m         <= '0;
                r_truth     <= '0;
                r_mismatch  <= '0;
                r_err_count <= '0;
                r_pass      <= 1'b0;
                r_exp_q     <= expected;
                r_busy      <= 1'b1;
            end
            if (w_sample) begin
                r_truth[r_m] <= dut_f;
                // the last minterm stays put; FINISH returns m to zero
                if (r_m != M_LAST) begin
                    r_m <= r_m + M_ONE;
                end
            end
            if (w_finish) begin
                r_mismatch  <= r_truth ^ r_exp_q;
                r_err_count <= popcount(r_truth ^ r_exp_q);
                r_pass      <= (popcount(r_truth ^ r_exp_q) == '0);
                r_busy      <= 1'b0;
                r_m         <= '0;
            end
            if (w_abort_take) begin
                r_busy <= 1'b0;
                r_m    <= '0;
            end
        end
    end

    assign dut_a     = r_m[3];
    assign dut_b     = r_m[2];
    assign dut_c     = r_m[1];
    assign dut_d     = r_m[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign truth     = r_truth;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;
    assign pass      = r_pass;

endmodule

// File: doc/minterm_sweep_ctrl.md
Name: minterm_sweep_ctrl

Overview:
Sequencer that exercises a 4-input combinational function block exhaustively. It drives A/B/C/D through all 16 minterms and waits a programmable settle time per minterm. It samples the block's output F, builds a 16-bit truth table and compares it against an expected mask. It sits between the function block and a self-check/status interface, with a start/done handshake.

Parameters:
SETTLE_CYCLES, 1, extra cycles each minterm is held before F is sampled (0..15 legal)
N_IN, 4, number of function inputs; fixed at 4, table width 2**N_IN = 16

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a sweep; honoured only in IDLE
abort  input  1  cancel a sweep in progress
expected  input  16  expected truth table, bit m = F at minterm m; captured on accepted start
dut_f  input  1  F output of the function block under control
dut_a  output  1  drive to input A (minterm bit 3, MSB)
dut_b  output  1  drive to input B (minterm bit 2)
dut_c  output  1  drive to input C (minterm bit 1)
dut_d  output  1  drive to input D (minterm bit 0, LSB)
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at sweep completion
aborted  output  1  one-cycle pulse when abort is taken
truth  output  16  captured truth table
mismatch  output  16  truth XOR expected_q; valid from done
err_count  output  5  popcount(mismatch), 0..16
pass  output  1  high when err_count == 0; valid from done, held until next start

Behaviour:
- All outputs are registered. Reset values: every output is 0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 accepts the sweep: m<=0, truth<=0, mismatch<=0, err_count<=0, pass<=0, expected_q<=expected, settle counter<=0, busy<=1, go to SETTLE (or SAMPLE if SETTLE_CYCLES=0).
  - Outputs dut_* = m[3:0]; m=0 drives all zeros.
- SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - truth[m]<=dut_f.
  - If m==15, go to FINISH. Otherwise m<=m+1, counter<=0, go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES=0).
  - dut_* changes only on the SAMPLE->next edge.
- Each minterm occupies exactly SETTLE_CYCLES+1 cycles. F is sampled in the last cycle of the slot.
- FINISH (one cycle):
  - Compute mismatch=truth^expected_q, err_count=popcount, pass=(err_count==0).
  - done=1 for this cycle only, busy<=0, m<=0, dut_*<=0, go to IDLE.
- Latency: with start accepted on edge k, done is high in the cycle after edge k+16*(SETTLE_CYCLES+1)+1. With the default that is 34 cycles after start.
- Boundary and simultaneous-event rules:
  - start while busy or in FINISH: ignored; no restart and no recapture of expected.
  - start and abort both high in IDLE: abort has no effect and start is accepted.
  - abort while busy, in any state including the final SAMPLE: go to IDLE. aborted=1 for one cycle, busy=0, dut_*=0, done not pulsed. truth holds partial content; mismatch, err_count and pass remain 0.
  - abort in FINISH: ignored; done still pulses.
  - rst mid-sweep: all state and outputs return to reset values on the next edge, with no done or aborted pulse.
- m counter wraps from 15 only via FINISH; it never increments past 15.
- Results (truth, mismatch, err_count, pass) are held in IDLE until the next accepted start.

Decomposition:
- Package minterm_sweep_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, FINISH);
  - N_IN and TT_W=16 constants;
  - GOLDEN_MASK=16'hF830, the truth table of F = A&(C&D | B) | B&~C, used by benches.
- One sub-module: sweep_settle_ctr.
  - Parameterised down-counter with load/clear and terminal flag.
  - Instantiated once for the per-minterm settle timing.
- Popcount is an inline function in the package.

Test Plan:
- Function F = A(CD+B)+BC' connected, expected=16'hF830, SETTLE_CYCLES=1, pulse start -> done after 34 cycles, truth=16'hF830, err_count=0, pass=1; dut_* steps 0..15 with each value held 2 cycles.
- Same circuit, expected=16'hF831 -> mismatch=16'h0001, err_count=1, pass=0.
- dut_f tied to 1, expected=16'h0000 -> truth=16'hFFFF, err_count=16, pass=0; SETTLE_CYCLES=0 build -> done 18 cycles after start.
- Abort asserted while m=7 -> aborted pulse, done never asserts, busy=0, dut_*=0, err_count=0, truth[6:0] captured and truth[15:7]=0.
- start re-pulsed at m=3 and during FINISH -> ignored, single done pulse, expected_q unchanged; then a new start from IDLE clears results and runs a fresh sweep.
- rst asserted at m=10 -> next cycle all outputs 0 and state IDLE; subsequent start completes normally with pass=1.
